// File: rtl/demux1x4_buf.sv
// demux1x4_buf: DEPTH-entry FIFO that routes each buffered word to one of
// four consumers. Words leave strictly in acceptance order. The head entry
// is presented on all four buses, and only the port named by its select
// field sees out_valid. A stalled head blocks later words (head-of-line
// blocking is intended). The storage array has no reset. Outputs are
// forced to zero while the buffer is empty, so stale contents never show.
module demux1x4_buf #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [1:0]                 select,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out1,
  output logic [DATA_W-1:0]          out2,
  output logic [DATA_W-1:0]          out3,
  output logic [DATA_W-1:0]          out4,
  output logic [3:0]                 out_valid,
  input  logic [3:0]                 out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // One-hot destination decode for a 2-bit select.
  function automatic logic [3:0] sel_onehot(input logic [1:0] s);
    logic [3:0] oh;
    oh    = 4'b0000;
    oh[s] = 1'b1;
    return oh;
  endfunction

  // Buffer storage (data path, no reset) and control state.
  logic [DATA_W-1:0] data_mem_p0 [DEPTH];
  logic [1:0]        sel_mem_p0  [DEPTH];
  logic [AW-1:0]     wr_ptr_p0;
  logic [AW-1:0]     rd_ptr_p0;
  logic [CW-1:0]     cnt_p0;

  logic              empty;
  logic              push;
  logic              pop;
  logic [1:0]        head_sel;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] out_bus;

  assign empty     = (cnt_p0 == '0);
  assign in_ready  = (cnt_p0 < FULL_CNT);
  assign head_sel  = sel_mem_p0[rd_ptr_p0];
  assign head_data = data_mem_p0[rd_ptr_p0];

  // Acceptance depends only on registered count. A pop needs a nonempty
  // buffer, so a word pushed into an empty buffer cannot leave on the same
  // edge. Ready bits of unselected ports are masked out by out_valid.
  assign push = in_valid && in_ready;
  assign pop  = |(out_valid & out_ready);

  // ---- stage p0: head presentation (registered state only) ----
  // Drive the head word on all buses and flag only its destination.
  always_comb begin
    out_valid = 4'b0000;
    out_bus   = '0;
    if (!empty) begin
      out_valid = sel_onehot(head_sel);
      out_bus   = head_data;
    end
  end

  assign out1  = out_bus;
  assign out2  = out_bus;
  assign out3  = out_bus;
  assign out4  = out_bus;
  assign count = cnt_p0;

  // Write the accepted word and its destination at the tail slot.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem_p0[wr_ptr_p0] <= in_data;
      sel_mem_p0[wr_ptr_p0]  <= select;
    end
  end

  // Pointers and occupancy. A synchronous reset drops every buffered entry
  // and overrides any push or pop on the same edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      cnt_p0    <= '0;
    end else begin
      if (push) wr_ptr_p0 <= (wr_ptr_p0 == AW'(DEPTH - 1)) ? '0 : wr_ptr_p0 + AW'(1);
      if (pop)  rd_ptr_p0 <= (rd_ptr_p0 == AW'(DEPTH - 1)) ? '0 : rd_ptr_p0 + AW'(1);
      case ({push, pop})
        2'b10:   cnt_p0 <= cnt_p0 + CW'(1);
        2'b01:   cnt_p0 <= cnt_p0 - CW'(1);
        default: cnt_p0 <= cnt_p0;
      endcase
    end
  end

endmodule

// File: tb/tb_demux1x4_buf.sv
// tb_demux1x4_buf: table of directed vectors for the corner scenarios,
// then a randomized stream checked against a queue-based reference model.
// A delivery log is built from what the DUT hands to ready consumers.
module tb_demux1x4_buf;

  localparam int DEPTH = 2;
  localparam int NWORDS = 1000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic [1:0]  select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out1, out2, out3, out4;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [$clog2(DEPTH):0] count;

  always #5 clock = ~clock;

  demux1x4_buf #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .select(select),
    .in_valid(in_valid), .in_ready(in_ready), .out1(out1), .out2(out2),
    .out3(out3), .out4(out4), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } word_t;

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  ordy;
    int          e_cnt;
    logic [3:0]  e_vld;
    logic        e_rdy;
    logic [31:0] e_out;
  } vec_t;

  word_t q[$];
  word_t sent[$];
  word_t seen[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] port_out(input int k);
    case (k)
      0: return out1;
      1: return out2;
      2: return out3;
      default: return out4;
    endcase
  endfunction

  // Apply one cycle of inputs, log deliveries, advance the reference queue.
  task automatic step(input logic r, input logic iv, input logic [1:0] s,
                      input logic [31:0] d, input logic [3:0] ordy);
    bit m_push, m_pop;
    word_t w;
    reset_n   = r;
    in_valid  = iv;
    select    = s;
    in_data   = d;
    out_ready = ordy;
    w.sel  = s;
    w.data = d;
    if (r) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && ordy[k]) begin
          word_t o;
          o.sel  = 2'(k);
          o.data = port_out(k);
          seen.push_back(o);
        end
      end
    end
    m_push = r && iv && (q.size() < DEPTH);
    m_pop  = r && (q.size() > 0) && ordy[q[0].sel];
    @(posedge clock);
    #1;
    if (!r) q.delete();
    else begin
      if (m_pop) q.delete(0);
      if (m_push) begin
        q.push_back(w);
        sent.push_back(w);
      end
    end
  endtask

  task automatic check_model();
    logic [3:0]  exp_v;
    logic [31:0] exp_d;
    exp_v = 4'b0000;
    exp_d = 32'h0;
    if (q.size() > 0) begin
      exp_v[q[0].sel] = 1'b1;
      exp_d = q[0].data;
    end
    chk("rnd_count", 32'(count), 32'(q.size()));
    chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("rnd_out_valid", 32'(out_valid), 32'(exp_v));
    chk("rnd_out1", out1, exp_d);
    chk("rnd_out2", out2, exp_d);
    chk("rnd_out3", out3, exp_d);
    chk("rnd_out4", out4, exp_d);
  endtask

  vec_t tbl[18];

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; select = 2'b00; in_data = '0; out_ready = 4'b0000;

    // rst, iv, sel, data, ordy -> count, out_valid, in_ready, out bus
    tbl[0]  = '{1'b0, 1'b0, 2'd0, 32'h0,         4'hF, 0, 4'b0000, 1'b1, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 2'd2, 32'hA5A5_0001, 4'hF, 1, 4'b0100, 1'b1, 32'hA5A5_0001};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 32'h0,         4'hF, 0, 4'b0000, 1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 2'd0, 32'h1111_1111, 4'h0, 1, 4'b0001, 1'b1, 32'h1111_1111};
    tbl[4]  = '{1'b1, 1'b1, 2'd1, 32'h2222_2222, 4'h0, 2, 4'b0001, 1'b0, 32'h1111_1111};
    tbl[5]  = '{1'b1, 1'b1, 2'd2, 32'h3333_3333, 4'h0, 2, 4'b0001, 1'b0, 32'h1111_1111};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 32'h0,         4'hF, 1, 4'b0010, 1'b1, 32'h2222_2222};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 32'h0,         4'hF, 0, 4'b0000, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 2'd0, 32'h0000_0001, 4'h8, 1, 4'b0001, 1'b1, 32'h0000_0001};
    tbl[9]  = '{1'b1, 1'b1, 2'd3, 32'h0000_0002, 4'h8, 2, 4'b0001, 1'b0, 32'h0000_0001};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 32'h0,         4'h8, 2, 4'b0001, 1'b0, 32'h0000_0001};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 32'h0,         4'h1, 1, 4'b1000, 1'b1, 32'h0000_0002};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 32'h0,         4'h8, 0, 4'b0000, 1'b1, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 2'd1, 32'hAAAA_0001, 4'h0, 1, 4'b0010, 1'b1, 32'hAAAA_0001};
    tbl[14] = '{1'b1, 1'b1, 2'd2, 32'hBBBB_0002, 4'h2, 1, 4'b0100, 1'b1, 32'hBBBB_0002};
    tbl[15] = '{1'b1, 1'b1, 2'd3, 32'hCCCC_0003, 4'h0, 2, 4'b0100, 1'b0, 32'hBBBB_0002};
    tbl[16] = '{1'b0, 1'b1, 2'd0, 32'hDDDD_0004, 4'hF, 0, 4'b0000, 1'b1, 32'h0};
    tbl[17] = '{1'b1, 1'b0, 2'd0, 32'h0,         4'hF, 0, 4'b0000, 1'b1, 32'h0};

    @(posedge clock);
    #1;
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].rst_n, tbl[i].iv, tbl[i].sel, tbl[i].data, tbl[i].ordy);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_out1", i), out1, tbl[i].e_out);
      chk($sformatf("vec%0d_out2", i), out2, tbl[i].e_out);
      chk($sformatf("vec%0d_out3", i), out3, tbl[i].e_out);
      chk($sformatf("vec%0d_out4", i), out4, tbl[i].e_out);
    end

    // Randomized stream against the reference queue.
    step(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    check_model();
    sent.delete();
    seen.delete();
    for (int cyc = 0; cyc < 20000 && sent.size() < NWORDS; cyc++) begin
      step(1'b1, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           $urandom, 4'($urandom_range(0, 15)));
      check_model();
    end
    for (int cyc = 0; cyc < 100 && q.size() > 0; cyc++) begin
      step(1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
      check_model();
    end
    chk("words_accepted", 32'(sent.size()), 32'(NWORDS));
    chk("words_delivered", 32'(seen.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size() && i < seen.size(); i++) begin
      chk($sformatf("deliv%0d_port", i), 32'(seen[i].sel), 32'(sent[i].sel));
      chk($sformatf("deliv%0d_data", i), seen[i].data, sent[i].data);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
